// File: rtl/per_addr_demux_pkg.sv
`default_nettype none
// ============================================================================
// per_demux_pkg : shared constants and helpers for the peripheral demux
// Revision 1.0 - initial release
// ============================================================================
package per_demux_pkg;

    localparam logic        OPC_OK    = 1'b0;
    localparam logic        OPC_ERR   = 1'b1;
    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/per_addr_demux_if.sv
`default_nettype none
// ============================================================================
// per_addr_demux_if : upstream request/response stream plus per-target fan-out
// Revision 1.0 - initial release
// ============================================================================
interface per_addr_demux_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int N_SLAVES   = 4
);
    logic                                     slv_req;
    logic [ADDR_WIDTH-1:0]                    slv_add;
    logic                                     slv_wen;
    logic [DATA_WIDTH-1:0]                    slv_wdata;
    logic [DATA_WIDTH/8-1:0]                  slv_be;
    logic                                     slv_gnt;
    logic                                     slv_r_valid;
    logic                                     slv_r_opc;
    logic [DATA_WIDTH-1:0]                    slv_r_rdata;

    logic [N_SLAVES-1:0]                      mst_req;
    logic [N_SLAVES-1:0][ADDR_WIDTH-1:0]      mst_add;
    logic [N_SLAVES-1:0]                      mst_wen;
    logic [N_SLAVES-1:0][DATA_WIDTH-1:0]      mst_wdata;
    logic [N_SLAVES-1:0][DATA_WIDTH/8-1:0]    mst_be;
    logic [N_SLAVES-1:0]                      mst_gnt;
    logic [N_SLAVES-1:0]                      mst_r_valid;
    logic [N_SLAVES-1:0]                      mst_r_opc;
    logic [N_SLAVES-1:0][DATA_WIDTH-1:0]      mst_r_rdata;

    // The demux is the slave of the upstream bridge and drives the targets.
    modport slave (
        input  slv_req, slv_add, slv_wen, slv_wdata, slv_be,
        output slv_gnt, slv_r_valid, slv_r_opc, slv_r_rdata,
        output mst_req, mst_add, mst_wen, mst_wdata, mst_be,
        input  mst_gnt, mst_r_valid, mst_r_opc, mst_r_rdata
    );

    modport master (
        output slv_req, slv_add, slv_wen, slv_wdata, slv_be,
        input  slv_gnt, slv_r_valid, slv_r_opc, slv_r_rdata,
        input  mst_req, mst_add, mst_wen, mst_wdata, mst_be,
        output mst_gnt, mst_r_valid, mst_r_opc, mst_r_rdata
    );

endinterface
`default_nettype wire

// File: rtl/per_addr_demux_err.sv
`default_nettype none
// ============================================================================
// per_err_slave : answers every accepted unmapped transfer one cycle later
// Revision 1.0 - initial release
// ============================================================================
module per_err_slave
    import per_demux_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_ni,
    input  wire logic                  accept,
    output logic                       rsp_valid,
    output logic                       rsp_opc,
    output logic [DATA_WIDTH-1:0]      rsp_rdata
);

    logic r_err_pending;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err_pending <= 1'b0;
        end else begin
            r_err_pending <= accept;
        end
    end

    assign rsp_valid = r_err_pending;
    assign rsp_opc   = OPC_ERR;
    assign rsp_rdata = DATA_WIDTH'(ERR_RDATA);

endmodule
`default_nettype wire

// File: rtl/per_addr_demux.sv
`default_nettype none
// ============================================================================
// per_addr_demux : address-decoded fan-out of the peripheral request stream
//                  with in-order, single-target outstanding tracking
// Revision 1.0 - initial release
// ============================================================================
module per_addr_demux
    import per_demux_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int N_SLAVES        = 4,
    parameter int SEL_LSB         = 10,
    parameter int SEL_WIDTH       = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    per_addr_demux_if.slave    bus,
    output logic               busy_o
);

    localparam int                CNT_W   = cnt_width(MAX_OUTSTANDING);
    localparam int                TGT_W   = cnt_width(N_SLAVES);
    localparam logic [TGT_W-1:0]  ERR_TGT = TGT_W'(N_SLAVES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0]       r_cnt;
    logic [TGT_W-1:0]       r_cur_tgt;

    logic [SEL_WIDTH-1:0]   w_sel;
    logic                   w_mapped;
    logic [TGT_W-1:0]       w_tgt;
    logic                   w_admit;
    logic                   w_tgt_gnt;
    logic                   w_gnt;
    logic                   w_accept;
    logic                   w_retire;
    logic                   w_rsp_valid;
    logic                   w_rsp_opc;
    logic [DATA_WIDTH-1:0]  w_rsp_rdata;
    logic                   w_err_valid;
    logic                   w_err_opc;
    logic [DATA_WIDTH-1:0]  w_err_rdata;
    wire  [N_SLAVES-1:0]    w_mst_req;
    wire  [N_SLAVES-1:0]    w_stray;

    assign w_sel    = bus.slv_add[SEL_LSB +: SEL_WIDTH];
    assign w_mapped = (32'(w_sel) < 32'(N_SLAVES));
    assign w_tgt    = w_mapped ? TGT_W'(w_sel) : ERR_TGT;

    // Only one target may own outstanding transfers; a retirement in the
    // same cycle deliberately does not free a slot.
    assign w_admit = (r_cnt == '0) || ((w_tgt == r_cur_tgt) && (r_cnt < CNT_MAX));

    always_comb begin
        w_tgt_gnt = !w_mapped;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (w_tgt == TGT_W'(i)) begin
                w_tgt_gnt = bus.mst_gnt[i];
            end
        end
    end

    assign w_gnt    = bus.slv_req & w_admit & w_tgt_gnt;
    assign w_accept = bus.slv_req & w_gnt;

    generate
        for (genvar g = 0; g < N_SLAVES; g++) begin : g_tgt
            assign w_mst_req[g] = bus.slv_req & w_admit & (w_tgt == TGT_W'(g));
            assign w_stray[g]   = bus.mst_r_valid[g] &
                                  ((r_cnt == '0) || (r_cur_tgt != TGT_W'(g)));
        end
    endgenerate

    assign bus.mst_req   = w_mst_req;
    assign bus.mst_add   = {N_SLAVES{bus.slv_add}};
    assign bus.mst_wen   = {N_SLAVES{bus.slv_wen}};
    assign bus.mst_wdata = {N_SLAVES{bus.slv_wdata}};
    assign bus.mst_be    = {N_SLAVES{bus.slv_be}};
    assign bus.slv_gnt   = w_gnt;

    per_err_slave #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_err (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .accept    (w_accept & !w_mapped),
        .rsp_valid (w_err_valid),
        .rsp_opc   (w_err_opc),
        .rsp_rdata (w_err_rdata)
    );

    always_comb begin
        w_rsp_valid = 1'b0;
        w_rsp_opc   = OPC_OK;
        w_rsp_rdata = '0;
        if (r_cur_tgt == ERR_TGT) begin
            w_rsp_valid = w_err_valid;
            w_rsp_opc   = w_err_opc;
            w_rsp_rdata = w_err_rdata;
        end else begin
            for (int i = 0; i < N_SLAVES; i++) begin
                if (r_cur_tgt == TGT_W'(i)) begin
                    w_rsp_valid = bus.mst_r_valid[i];
                    w_rsp_opc   = bus.mst_r_opc[i];
                    w_rsp_rdata = bus.mst_r_rdata[i];
                end
            end
        end
    end

    assign w_retire        = (r_cnt != '0) & w_rsp_valid;
    assign bus.slv_r_valid = w_retire;
    assign bus.slv_r_opc   = w_rsp_opc;
    assign bus.slv_r_rdata = w_rsp_rdata;
    assign busy_o          = (r_cnt != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt     <= '0;
            r_cur_tgt <= '0;
        end else begin
            if (w_accept) begin
                r_cur_tgt <= w_tgt;
            end
            case ({w_accept, w_retire})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Responses from a target that owns nothing are dropped by the mux above.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (w_stray == '0)
                else $warning("per_addr_demux: stray target response dropped (targets %b)", w_stray);
        end
    end

endmodule
`default_nettype wire
